// File: rtl/game_sprite_motion.sv
// game_sprite_motion
//   Moves a sprite inside an inclusive rectangle [X_MIN..X_MAX] x [Y_MIN..Y_MAX]
//   by a signed per-step velocity on each strobe. Reaching or crossing a bound
//   clamps the position and pulses edge_hit for one cycle.
//   Optional feature macro: GAME_SPRITE_BOUNCE_EN
//     defined   -> the velocity component that hit a bound is negated and the
//                  sprite keeps running
//     undefined -> the sprite stops in DONE at the clamped position
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   strobe             one-cycle motion tick
//   start              load clamped init position and velocity, enter RUN
//   stop               freeze and enter IDLE
//   x_init, y_init     start position
//   dx_init, dy_init   signed start velocity
//   x, y               registered sprite position
//   running            high while in RUN
//   edge_hit           one-cycle pulse on a bound event, aligned with x/y update
module game_sprite_motion #(
  parameter int X_WIDTH = 10,
  parameter int Y_WIDTH = 10,
  parameter int D_WIDTH = 4,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 639,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 479
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      strobe,
  input  logic                      start,
  input  logic                      stop,
  input  logic [X_WIDTH-1:0]        x_init,
  input  logic [Y_WIDTH-1:0]        y_init,
  input  logic signed [D_WIDTH-1:0] dx_init,
  input  logic signed [D_WIDTH-1:0] dy_init,
  output logic [X_WIDTH-1:0]        x,
  output logic [Y_WIDTH-1:0]        y,
  output logic                      running,
  output logic                      edge_hit
);

`ifdef GAME_SPRITE_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  // Two guard bits: one for carry past the top, one for sign below zero.
  localparam int XS = X_WIDTH + 2;
  localparam int YS = Y_WIDTH + 2;
  localparam logic signed [XS-1:0] XMIN_S = XS'(X_MIN);
  localparam logic signed [XS-1:0] XMAX_S = XS'(X_MAX);
  localparam logic signed [YS-1:0] YMIN_S = YS'(Y_MIN);
  localparam logic signed [YS-1:0] YMAX_S = YS'(Y_MAX);
  localparam logic signed [D_WIDTH-1:0] V_NEG_MAX = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic signed [D_WIDTH-1:0] V_POS_MAX = ~V_NEG_MAX;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state, state_next;
  logic signed [D_WIDTH-1:0] vx, vy;
  logic signed [XS-1:0]      nx;
  logic signed [YS-1:0]      ny;
  logic                      ex, ey, step;

  function automatic logic [X_WIDTH-1:0] clamp_x(input logic signed [XS-1:0] v);
    if (v < XMIN_S)      return XMIN_S[X_WIDTH-1:0];
    else if (v > XMAX_S) return XMAX_S[X_WIDTH-1:0];
    else                 return v[X_WIDTH-1:0];
  endfunction

  function automatic logic [Y_WIDTH-1:0] clamp_y(input logic signed [YS-1:0] v);
    if (v < YMIN_S)      return YMIN_S[Y_WIDTH-1:0];
    else if (v > YMAX_S) return YMAX_S[Y_WIDTH-1:0];
    else                 return v[Y_WIDTH-1:0];
  endfunction

  // Negation that saturates the most negative value to the most positive one.
  function automatic logic signed [D_WIDTH-1:0] neg_sat(input logic signed [D_WIDTH-1:0] v);
    if (v == V_NEG_MAX) return V_POS_MAX;
    else                return -v;
  endfunction

  // Candidate step and edge detection. With a zero velocity the position is
  // already in range, so "clamped or landed on a bound" collapses to
  // "at-or-beyond a bound with non-zero velocity".
  always_comb begin
    nx   = signed'({2'b00, x}) + XS'(vx);
    ny   = signed'({2'b00, y}) + YS'(vy);
    ex   = (vx != '0) && ((nx <= XMIN_S) || (nx >= XMAX_S));
    ey   = (vy != '0) && ((ny <= YMIN_S) || (ny >= YMAX_S));
    step = (state == RUN) && strobe;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start)                               state_next = RUN;
    else if (stop)                           state_next = IDLE;
    else if (!BOUNCE && step && (ex || ey))  state_next = DONE;
  end

  always_comb begin
    running = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= XMIN_S[X_WIDTH-1:0];
      y        <= YMIN_S[Y_WIDTH-1:0];
      vx       <= '0;
      vy       <= '0;
      edge_hit <= 1'b0;
    end else begin
      edge_hit <= 1'b0;
      if (start) begin
        x  <= clamp_x(signed'({2'b00, x_init}));
        y  <= clamp_y(signed'({2'b00, y_init}));
        vx <= dx_init;
        vy <= dy_init;
      end else if (!stop && step) begin
        x        <= clamp_x(nx);
        y        <= clamp_y(ny);
        edge_hit <= ex || ey;
        if (BOUNCE) begin
          if (ex) vx <= neg_sat(vx);
          if (ey) vy <= neg_sat(vy);
        end
      end
    end
  end

endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed bench for game_sprite_motion with default parameters.
// Expected values are hand-computed; the bounce-dependent ones follow
// GAME_SPRITE_BOUNCE_EN as seen by this file.
module tb_game_sprite_motion;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              strobe = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic [9:0]        x_init = '0;
  logic [9:0]        y_init = '0;
  logic signed [3:0] dx_init = '0;
  logic signed [3:0] dy_init = '0;
  logic [9:0]        x, y;
  logic              running, edge_hit;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  game_sprite_motion #(
    .X_WIDTH(10), .Y_WIDTH(10), .D_WIDTH(4),
    .X_MIN(0), .X_MAX(639), .Y_MIN(0), .Y_MAX(479)
  ) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .start(start), .stop(stop),
    .x_init(x_init), .y_init(y_init), .dx_init(dx_init), .dy_init(dy_init),
    .x(x), .y(y), .running(running), .edge_hit(edge_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic load(input logic [9:0] xi, input logic [9:0] yi,
                      input logic signed [3:0] dx, input logic signed [3:0] dy);
    x_init = xi; y_init = yi; dx_init = dx; dy_init = dy;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_x", 32'(x), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_edge", 32'(edge_hit), 0);
    rst = 1'b0;
    tick();
    pulse_strobe();
    chk("idle_strobe_x", 32'(x), 0);
    chk("idle_run", 32'(running), 0);

    // Basic motion: 4 steps of (+3,-2)
    load(10'd100, 10'd50, 4'sd3, -4'sd2);
    chk("load_x", 32'(x), 100);
    chk("load_y", 32'(y), 50);
    chk("load_run", 32'(running), 1);
    for (int i = 0; i < 4; i++) begin
      pulse_strobe();
      chk("move_edge", 32'(edge_hit), 0);
    end
    chk("move_x", 32'(x), 112);
    chk("move_y", 32'(y), 42);
    chk("move_run", 32'(running), 1);

    // Right-edge crossing 637+5 -> clamp 639
    load(10'd637, 10'd100, 4'sd5, 4'sd0);
    pulse_strobe();
    chk("redge_x", 32'(x), 639);
    chk("redge_y", 32'(y), 100);
    chk("redge_pulse", 32'(edge_hit), 1);
    tick();
    chk("redge_pulse_end", 32'(edge_hit), 0);
`ifdef GAME_SPRITE_BOUNCE_EN
    chk("redge_run", 32'(running), 1);
    pulse_strobe();
    chk("redge_bounce_x", 32'(x), 634);
    chk("redge_bounce_edge", 32'(edge_hit), 0);
`else
    chk("redge_run", 32'(running), 0);
    pulse_strobe();
    chk("redge_done_x", 32'(x), 639);
    chk("redge_done_edge", 32'(edge_hit), 0);
`endif

    // Corner hit (1,1) with (-2,-2): both events, single pulse
    load(10'd1, 10'd1, -4'sd2, -4'sd2);
    pulse_strobe();
    chk("corner_x", 32'(x), 0);
    chk("corner_y", 32'(y), 0);
    chk("corner_pulse", 32'(edge_hit), 1);
    tick();
    chk("corner_pulse_end", 32'(edge_hit), 0);
`ifdef GAME_SPRITE_BOUNCE_EN
    pulse_strobe();
    chk("corner_bounce_x", 32'(x), 2);
    chk("corner_bounce_y", 32'(y), 2);
    // Most negative velocity bounces to the most positive: 5-8 -> 0, then +7
    load(10'd5, 10'd200, -4'sd8, 4'sd0);
    pulse_strobe();
    chk("vmin_x", 32'(x), 0);
    pulse_strobe();
    chk("vmin_bounce_x", 32'(x), 7);
`else
    chk("corner_run", 32'(running), 0);
    pulse_strobe();
    chk("corner_done_x", 32'(x), 0);
`endif

    // Init clamp, and landing exactly on a bound with zero velocity on the other axis
    load(10'd1000, 10'd1023, 4'sd0, 4'sd0);
    chk("iclamp_x", 32'(x), 639);
    chk("iclamp_y", 32'(y), 479);
    pulse_strobe();
    chk("stationary_edge", 32'(edge_hit), 0);
    load(10'd639, 10'd478, 4'sd0, 4'sd1);
    pulse_strobe();
    chk("yexact_y", 32'(y), 479);
    chk("yexact_x", 32'(x), 639);
    chk("yexact_pulse", 32'(edge_hit), 1);
`ifdef GAME_SPRITE_BOUNCE_EN
    pulse_strobe();
    chk("yexact_bounce_y", 32'(y), 478);
`else
    chk("yexact_run", 32'(running), 0);
`endif

    // start + strobe together: start wins, no step
    x_init = 10'd200; y_init = 10'd200; dx_init = 4'sd1; dy_init = 4'sd1;
    start = 1'b1; strobe = 1'b1;
    tick();
    start = 1'b0; strobe = 1'b0;
    chk("ss_x", 32'(x), 200);
    chk("ss_y", 32'(y), 200);
    // stop + start together: start wins
    x_init = 10'd300; y_init = 10'd300;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("sp_x", 32'(x), 300);
    chk("sp_y", 32'(y), 300);
    chk("sp_run", 32'(running), 1);

    // stop freezes; start resumes from new init
    pulse_strobe();
    chk("pre_stop_x", 32'(x), 301);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_run", 32'(running), 0);
    for (int i = 0; i < 3; i++) pulse_strobe();
    chk("frozen_x", 32'(x), 301);
    chk("frozen_y", 32'(y), 301);
    load(10'd10, 10'd20, 4'sd2, 4'sd3);
    pulse_strobe();
    chk("resume_x", 32'(x), 12);
    chk("resume_y", 32'(y), 23);

    // Asynchronous reset mid-RUN, between edges
    pulse_strobe();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_x", 32'(x), 0);
    chk("arst_y", 32'(y), 0);
    chk("arst_run", 32'(running), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) pulse_strobe();
    chk("post_rst_x", 32'(x), 0);
    chk("post_rst_y", 32'(y), 0);
    chk("post_rst_run", 32'(running), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
